// File: rtl/ptp_tod_wr_arb_if.sv
// Bundle between N ToD set sources and the PTP clock register write port.
// "master" is the arbiter's view; "slave" is the sources/register-block view.
interface ptp_tod_wr_arb_if #(
  parameter int CH_COUNT       = 2,
  parameter int REG_ADDR_WIDTH = 16,
  parameter int REG_DATA_WIDTH = 32,
  parameter int REG_STRB_WIDTH = REG_DATA_WIDTH / 8,
  parameter int CH_IDX_WIDTH   = (CH_COUNT > 1) ? $clog2(CH_COUNT) : 1
);
  logic [CH_COUNT-1:0]       s_tod_wr_en;
  logic [CH_COUNT*96-1:0]    s_tod_wr_ts;
  logic [CH_COUNT-1:0]       s_tod_wr_ack;
  logic [CH_COUNT-1:0]       s_tod_wr_err;
  logic [CH_COUNT-1:0]       ch_enable;
  logic [REG_ADDR_WIDTH-1:0] m_reg_wr_addr;
  logic [REG_DATA_WIDTH-1:0] m_reg_wr_data;
  logic [REG_STRB_WIDTH-1:0] m_reg_wr_strb;
  logic                      m_reg_wr_en;
  logic                      m_reg_wr_wait;
  logic                      m_reg_wr_ack;
  logic                      busy;
  logic [CH_IDX_WIDTH-1:0]   last_ch;

  modport master (
    input  s_tod_wr_en, s_tod_wr_ts, ch_enable, m_reg_wr_wait, m_reg_wr_ack,
    output s_tod_wr_ack, s_tod_wr_err, m_reg_wr_addr, m_reg_wr_data,
           m_reg_wr_strb, m_reg_wr_en, busy, last_ch
  );

  modport slave (
    output s_tod_wr_en, s_tod_wr_ts, ch_enable, m_reg_wr_wait, m_reg_wr_ack,
    input  s_tod_wr_ack, s_tod_wr_err, m_reg_wr_addr, m_reg_wr_data,
           m_reg_wr_strb, m_reg_wr_en, busy, last_ch
  );
endinterface

// File: rtl/ptp_tod_wr_arb.sv
// Round-robin arbiter turning 96-bit ToD set requests into ordered set-ToD register writes.
// Define PTP_TOD_FNS_WR_EN to prepend the fractional-ns register write (4 writes instead of 3).
module ptp_tod_wr_arb #(
  parameter int          CH_COUNT         = 2,
  parameter int          REG_ADDR_WIDTH   = 16,
  parameter int          REG_DATA_WIDTH   = 32,
  parameter int          REG_STRB_WIDTH   = REG_DATA_WIDTH / 8,
  parameter logic [31:0] CLK_RB_BASE_ADDR = 32'h200,
  parameter int          TIMEOUT_CYCLES   = 1024
) (
  input logic            clk,
  input logic            rst,
  ptp_tod_wr_arb_if.master bus
);

  localparam int CH_IDX_W = (CH_COUNT > 1) ? $clog2(CH_COUNT) : 1;
  localparam int TMO_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [31:0] NS_PER_SEC = 32'd1_000_000_000;

`ifdef PTP_TOD_FNS_WR_EN
  localparam int TS_LO = 0;
`else
  // fns is never written, so it is not even latched
  localparam int TS_LO = 16;
`endif

  typedef enum logic [2:0] {
    IDLE,
    WR_FNS,
    WR_NS,
    WR_SEC_L,
    WR_SEC_H,
    DONE
  } state_t;

`ifdef PTP_TOD_FNS_WR_EN
  localparam state_t FIRST_WR = WR_FNS;
`else
  localparam state_t FIRST_WR = WR_NS;
`endif

  state_t                    state_reg;
  logic [CH_IDX_W-1:0]       ch_reg;
  logic [CH_IDX_W-1:0]       last_ch_reg;
  logic                      busy_reg;
  logic [95:TS_LO]           ts_reg;
  logic [TMO_W-1:0]          tmo_cnt_reg;
  logic                      wr_en_reg;
  logic [REG_ADDR_WIDTH-1:0] wr_addr_reg;
  logic [REG_DATA_WIDTH-1:0] wr_data_reg;
  logic [REG_STRB_WIDTH-1:0] wr_strb_reg;
  logic [CH_COUNT-1:0]       ack_reg;
  logic [CH_COUNT-1:0]       err_reg;

  logic [CH_COUNT-1:0]       req_vec;
  logic [95:TS_LO]           ts_arr [CH_COUNT];
  logic                      grant_vld;
  logic [CH_IDX_W-1:0]       grant_idx;

  assign req_vec = bus.s_tod_wr_en & bus.ch_enable;

  for (genvar gi = 0; gi < CH_COUNT; gi++) begin : g_ts
    assign ts_arr[gi] = bus.s_tod_wr_ts[gi*96+TS_LO +: 96-TS_LO];
  end

  // Scan from farthest to nearest after last_ch so the nearest requester wins.
  always_comb begin
    int c;
    c         = 0;
    grant_vld = 1'b0;
    grant_idx = '0;
    for (int i = CH_COUNT; i >= 1; i--) begin
      c = (int'(last_ch_reg) + i) % CH_COUNT;
      if (req_vec[c[CH_IDX_W-1:0]]) begin
        grant_vld = 1'b1;
        grant_idx = c[CH_IDX_W-1:0];
      end
    end
  end

  function automatic logic [REG_ADDR_WIDTH-1:0] wr_addr_of(input state_t s);
    logic [31:0] off;
    case (s)
      WR_FNS:   off = 32'h30;
      WR_NS:    off = 32'h34;
      WR_SEC_L: off = 32'h38;
      default:  off = 32'h3C;
    endcase
    return REG_ADDR_WIDTH'(CLK_RB_BASE_ADDR + off);
  endfunction

  function automatic logic [REG_DATA_WIDTH-1:0] wr_data_of(input state_t s, input logic [95:TS_LO] ts);
    logic [31:0] d;
    case (s)
`ifdef PTP_TOD_FNS_WR_EN
      WR_FNS:   d = {ts[15:0], 16'd0};
`endif
      WR_NS:    d = ts[47:16];
      WR_SEC_L: d = ts[79:48];
      default:  d = {16'd0, ts[95:80]};
    endcase
    return REG_DATA_WIDTH'(d);
  endfunction

  function automatic state_t next_of(input state_t s);
    case (s)
      WR_FNS:   return WR_NS;
      WR_NS:    return WR_SEC_L;
      WR_SEC_L: return WR_SEC_H;
      default:  return DONE;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      ch_reg      <= '0;
      last_ch_reg <= CH_IDX_W'(CH_COUNT - 1);
      busy_reg    <= 1'b0;
      ts_reg      <= '0;
      tmo_cnt_reg <= '0;
      wr_en_reg   <= 1'b0;
      wr_addr_reg <= '0;
      wr_data_reg <= '0;
      wr_strb_reg <= '0;
      ack_reg     <= '0;
      err_reg     <= '0;
    end else begin
      ack_reg <= '0;
      err_reg <= '0;
      unique case (state_reg)
        IDLE: begin
          if (grant_vld) begin
            ch_reg      <= grant_idx;
            last_ch_reg <= grant_idx;
            busy_reg    <= 1'b1;
            ts_reg      <= ts_arr[grant_idx];
            tmo_cnt_reg <= '0;
            if (ts_arr[grant_idx][47:16] >= NS_PER_SEC) begin
              // out-of-range ns: reject without touching the clock
              state_reg          <= DONE;
              ack_reg[grant_idx] <= 1'b1;
              err_reg[grant_idx] <= 1'b1;
            end else begin
              state_reg   <= FIRST_WR;
              wr_en_reg   <= 1'b1;
              wr_strb_reg <= '1;
              wr_addr_reg <= wr_addr_of(FIRST_WR);
              wr_data_reg <= wr_data_of(FIRST_WR, ts_arr[grant_idx]);
            end
          end
        end
        WR_FNS, WR_NS, WR_SEC_L, WR_SEC_H: begin
          if (bus.m_reg_wr_ack) begin
            tmo_cnt_reg <= '0;
            if (state_reg == WR_SEC_H) begin
              state_reg       <= DONE;
              wr_en_reg       <= 1'b0;
              wr_strb_reg     <= '0;
              ack_reg[ch_reg] <= 1'b1;
            end else begin
              state_reg   <= next_of(state_reg);
              wr_addr_reg <= wr_addr_of(next_of(state_reg));
              wr_data_reg <= wr_data_of(next_of(state_reg), ts_reg);
            end
          end else if (bus.m_reg_wr_wait) begin
            tmo_cnt_reg <= '0;
          end else if (tmo_cnt_reg == TMO_W'(TIMEOUT_CYCLES - 1)) begin
            // target unresponsive: abandon the remaining writes
            state_reg       <= DONE;
            wr_en_reg       <= 1'b0;
            wr_strb_reg     <= '0;
            ack_reg[ch_reg] <= 1'b1;
            err_reg[ch_reg] <= 1'b1;
          end else begin
            tmo_cnt_reg <= tmo_cnt_reg + 1'b1;
          end
        end
        DONE: begin
          busy_reg  <= 1'b0;
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.s_tod_wr_ack  = ack_reg;
  assign bus.s_tod_wr_err  = err_reg;
  assign bus.m_reg_wr_addr = wr_addr_reg;
  assign bus.m_reg_wr_data = wr_data_reg;
  assign bus.m_reg_wr_strb = wr_strb_reg;
  assign bus.m_reg_wr_en   = wr_en_reg;
  assign bus.busy          = busy_reg;
  assign bus.last_ch       = last_ch_reg;

endmodule
